dram_initiator: RTL and testbench

- Requester-side master for the DRAM port protocol (addr_i / cs / we / data_i / data_o / ack).
- Sits between the CPU data-memory stage and the DRAM model.
- Converts a level-held CPU request into a single-cycle cs strobe, holds address and write data until ack, then returns read data and releases the pipeline stall.
- One outstanding transaction at a time.

---
 rtl/dram_if_pkg.sv | 16 +
 rtl/dram_wdt.sv | 37 +++
 rtl/dram_initiator.sv | 139 +++++++++++++
 tb/tb_dram_initiator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_if_pkg.sv
// Shared types and defaults for the DRAM port requester.
// Optional watchdog is enabled with DRAM_TIMEOUT_EN.
package dram_if_pkg;

  localparam int unsigned DefAddrW         = 32;
  localparam int unsigned DefDataW         = 32;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } dram_state_e;

endpackage

// File: rtl/dram_wdt.sv
// WAIT-state watchdog: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_CYCLES-1 is reached. Used only with DRAM_TIMEOUT_EN.
module dram_wdt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  assign expired = (count_q == Limit);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dram_initiator.sv
// Requester-side DRAM port master: one outstanding transaction, single-cycle cs.
// Define DRAM_TIMEOUT_EN to add the WAIT-state watchdog and err_o reporting.
module dram_initiator
  import dram_if_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  dram_state_e       state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef DRAM_TIMEOUT_EN
  logic err_q, err_d;
  logic wdt_expired;

  // Clearing during ISSUE makes the count start at zero on the first WAIT cycle.
  dram_wdt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == StIssue),
    .enable  (state_q == StWait),
    .expired (wdt_expired)
  );
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef DRAM_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // A zero-delay responder acks in the strobe cycle itself.
        if (mem_ack_i) begin
          if (!we_q) begin
            rdata_d = mem_data_i;
          end
          state_d = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_ack_i) begin
          if (!we_q) begin
            rdata_d = mem_data_i;
          end
          state_d = StDone;
        end
`ifdef DRAM_TIMEOUT_EN
        else if (wdt_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef DRAM_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef DRAM_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign stall_o    = ((state_q == StIdle) && req_valid_i) ||
                      (state_q == StIssue) || (state_q == StWait);
  assign mem_cs_o   = (state_q == StIssue);
  assign mem_we_o   = (state_q == StIssue) && we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;
  assign done_o     = (state_q == StDone);
  assign rdata_o    = rdata_q;
`ifdef DRAM_TIMEOUT_EN
  assign err_o      = err_q;
`else
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_dram_initiator.sv
// Directed bench for dram_initiator: a vector table of transactions run against
// a small DRAM responder, plus hand sequences for ack/reset/timeout corners.
module tb_dram_initiator;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i;
  logic          req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          stall_o;
  logic [DW-1:0] rdata_o;
  logic          done_o;
  logic          err_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_cs_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_data_i;
  logic          mem_ack_i;

  always #5 clk = ~clk;

  dram_initiator #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .stall_o     (stall_o),
    .rdata_o     (rdata_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_cs_o    (mem_cs_o),
    .mem_we_o    (mem_we_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  int n_vec  = 0;
  int n_fail = 0;
  logic [DW-1:0] mem [0:15];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one transaction from IDLE; responder acks 'delay' cycles after cs.
  task automatic run_txn(input string tag, input vec_t v);
    int   cs_cyc    = -1;
    int   cs_cnt    = 0;
    int   stall_cnt = 1;
    int   done_cyc  = -1;
    logic we_bad    = 1'b0;
    logic data_bad  = 1'b0;
    logic addr_bad  = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = v.we;
    req_addr_i  = v.addr;
    req_wdata_i = v.wdata;
    #1;
    check({tag, " stall_on_req"}, 32'(stall_o), 32'd1);
    for (int i = 1; i <= 100 && done_cyc < 0; i++) begin
      tick();
      mem_ack_i  = 1'b0;
      mem_data_i = 32'hbad0_0000 | 32'(i);
      if (mem_cs_o) begin
        cs_cnt++;
        cs_cyc = i;
        if (mem_we_o !== v.we) we_bad = 1'b1;
        if (mem_data_o !== v.wdata) data_bad = 1'b1;
        if (v.we) mem[v.addr[3:0]] = mem_data_o;
      end else if (mem_we_o) begin
        we_bad = 1'b1;
      end
      if (mem_addr_o !== v.addr) addr_bad = 1'b1;
      if (i == 2) begin
        req_addr_i  = v.addr ^ 32'h55;
        req_wdata_i = ~v.wdata;
        req_we_i    = ~v.we;
      end
      if (done_o) begin
        done_cyc = i;
        check({tag, " rdata"}, rdata_o, v.exp_rdata);
        check({tag, " stall_in_done"}, 32'(stall_o), 32'd0);
        check({tag, " err"}, 32'(err_o), 32'd0);
      end else begin
        if (stall_o) stall_cnt++;
        if (cs_cyc >= 0 && i == cs_cyc + v.delay) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem[v.addr[3:0]];
        end
      end
    end
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(v.exp_lat));
    check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(v.exp_lat));
    check({tag, " cs_count"}, 32'(cs_cnt), 32'd1);
    check({tag, " we_strobe"}, 32'(we_bad), 32'd0);
    check({tag, " mem_data"}, 32'(data_bad), 32'd0);
    check({tag, " addr_held"}, 32'(addr_bad), 32'd0);
    tick();
    req_valid_i = 1'b0;
    mem_ack_i   = 1'b0;
    check({tag, " done_pulse"}, 32'(done_o), 32'd0);
    tick();
    check({tag, " idle_cs"}, 32'(mem_cs_o), 32'd0);
  endtask

  initial begin
    int done_cyc;
    vecs[0] = '{we: 1'b1, addr: 2, wdata: 10,           delay: 10, exp_rdata: 0,            exp_lat: 12};
    vecs[1] = '{we: 1'b0, addr: 2, wdata: 32'h1111,     delay: 3,  exp_rdata: 10,           exp_lat: 5};
    vecs[2] = '{we: 1'b1, addr: 2, wdata: 120,          delay: 0,  exp_rdata: 10,           exp_lat: 2};
    vecs[3] = '{we: 1'b0, addr: 2, wdata: 32'h2222,     delay: 0,  exp_rdata: 120,          exp_lat: 2};
    vecs[4] = '{we: 1'b1, addr: 7, wdata: 32'hdeadbeef, delay: 1,  exp_rdata: 120,          exp_lat: 3};
    vecs[5] = '{we: 1'b0, addr: 7, wdata: 32'h3333,     delay: 2,  exp_rdata: 32'hdeadbeef, exp_lat: 4};
    for (int i = 0; i < 16; i++) mem[i] = '0;

    rst         = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    mem_data_i  = '0;
    mem_ack_i   = 1'b0;
    tick();
    tick();
    check("rst stall", 32'(stall_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst cs", 32'(mem_cs_o), 32'd0);
    check("rst we", 32'(mem_we_o), 32'd0);
    check("rst addr", mem_addr_o, 32'd0);
    check("rst mem_data", mem_data_o, 32'd0);
    check("rst rdata", rdata_o, 32'd0);
    check("rst err", 32'(err_o), 32'd0);
    rst = 1'b0;
    tick();

    // Spurious ack in IDLE must not start anything.
    mem_ack_i  = 1'b1;
    mem_data_i = 32'hfeed;
    tick();
    tick();
    mem_ack_i = 1'b0;
    check("spurious done", 32'(done_o), 32'd0);
    check("spurious cs", 32'(mem_cs_o), 32'd0);
    check("spurious stall", 32'(stall_o), 32'd0);
    check("spurious rdata", rdata_o, 32'd0);

    for (int k = 0; k < 6; k++) begin
      run_txn($sformatf("vec%0d", k), vecs[k]);
    end

    // Reset while in WAIT, then a late ack from the aborted read.
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 2;
    tick();
    check("abort cs", 32'(mem_cs_o), 32'd1);
    tick();
    tick();
    check("abort wait_stall", 32'(stall_o), 32'd1);
    rst         = 1'b1;
    req_valid_i = 1'b0;
    #1;
    check("abort stall", 32'(stall_o), 32'd0);
    check("abort cs0", 32'(mem_cs_o), 32'd0);
    check("abort addr", mem_addr_o, 32'd0);
    check("abort rdata", rdata_o, 32'd0);
    tick();
    rst        = 1'b0;
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h5a5a;
    tick();
    mem_ack_i = 1'b0;
    check("late_ack done", 32'(done_o), 32'd0);
    tick();
    check("late_ack done2", 32'(done_o), 32'd0);
    check("late_ack rdata", rdata_o, 32'd0);
    run_txn("post_abort", '{we: 1'b0, addr: 2, wdata: 0, delay: 4, exp_rdata: 120, exp_lat: 6});

    // Responder never acks.
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 3;
    req_wdata_i = 32'h33;
    done_cyc    = -1;
`ifdef DRAM_TIMEOUT_EN
    for (int i = 1; i <= 40 && done_cyc < 0; i++) begin
      tick();
      if (done_o) begin
        done_cyc = i;
        check("tmo err", 32'(err_o), 32'd1);
        check("tmo rdata", rdata_o, 32'd0);
      end
    end
    check("tmo done_cycle", 32'(done_cyc), 32'(TMO + 2));
    tick();
    req_valid_i = 1'b0;
    check("tmo err_pulse", 32'(err_o), 32'd0);
`else
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_o && done_cyc < 0) done_cyc = i;
    end
    check("noack done", 32'(done_cyc), 32'hffffffff);
    check("noack stall", 32'(stall_o), 32'd1);
    check("noack err", 32'(err_o), 32'd0);
    rst         = 1'b1;
    req_valid_i = 1'b0;
    tick();
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
